// File: rtl/axi_prefetch_pkg.sv
// axi_prefetch_pkg: shared defaults and control state type for the prefetch stream buffer
package axi_prefetch_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_BURST_LEN = 16;
  localparam int DEF_PTR_W = $clog2(DEF_DEPTH);
  typedef enum logic [1:0] {IDLE, KICK, WAIT, HALT} state_t;
endpackage

// File: rtl/prefetch_sdp_ram.sv
// prefetch_sdp_ram: simple dual-port RAM, one write port and a registered read port
module prefetch_sdp_ram
  import axi_prefetch_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH,
  parameter int AW = DEF_PTR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_prefetch_stream_buf.sv
// axi_prefetch_stream_buf: kicks AXI prefetch bursts into a RAM FIFO and streams it out on AXI-Stream
module axi_prefetch_stream_buf
  import axi_prefetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    enable,
  output logic                    INIT_AXI_TXN,
  input  logic                    TXN_DONE,
  input  logic                    TXN_ERROR,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] KICK_MAX = (AW+1)'(DEPTH - BURST_LEN);
  state_t state;
  logic [AW-1:0] wp, rp, out_cnt;
  logic done_q, done_rise, wr, rd, acc, kick;
  assign acc = m_axis_tvalid & m_axis_tready;
  assign wr = in_valid & (level != FULL);
  assign rd = (level > {{AW{1'b0}}, m_axis_tvalid}) & (~m_axis_tvalid | m_axis_tready);
  assign done_rise = TXN_DONE & ~done_q;
  assign kick = (state == IDLE) & enable & (level <= KICK_MAX);
  assign m_axis_tlast = m_axis_tvalid & (out_cnt == AW'(DEPTH - 1));
  prefetch_sdp_ram #(.DW(DATA_WIDTH), .AW(AW)) u_ram (
    .clk(ACLK),
    .we(wr),
    .waddr(wp),
    .wdata(in_data),
    .re(rd),
    .raddr(rp),
    .rdata(m_axis_tdata)
  );
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= IDLE;
      INIT_AXI_TXN <= 1'b0;
      done_q <= 1'b0;
      wp <= '0;
      rp <= '0;
      out_cnt <= '0;
      level <= '0;
      m_axis_tvalid <= 1'b0;
      overflow <= 1'b0;
      error <= 1'b0;
    end else begin
      done_q <= TXN_DONE;
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      out_cnt <= out_cnt + AW'(acc);
      level <= level + (AW+1)'(wr) - (AW+1)'(acc);
      m_axis_tvalid <= rd | (m_axis_tvalid & ~m_axis_tready);
      overflow <= overflow | (in_valid & ~wr);
      INIT_AXI_TXN <= kick;
      case (state)
        IDLE: state <= kick ? KICK : IDLE;
        KICK: state <= WAIT;
        WAIT: if (done_rise) begin
          state <= TXN_ERROR ? HALT : IDLE;
          error <= error | TXN_ERROR;
        end
        HALT: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_prefetch_stream_buf.sv
// tb_axi_prefetch_stream_buf: random upstream/downstream traffic scored against a queue-based model
module tb_axi_prefetch_stream_buf;
  localparam int DW = 32;
  localparam int DEPTH = 256;
  localparam int BL = 16;
  logic tb_ACLK = 1'b0;
  logic ARESETN = 1'b0, enable = 1'b0, TXN_DONE = 1'b0, TXN_ERROR = 1'b0;
  logic in_valid = 1'b0, m_axis_tready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic INIT_AXI_TXN, m_axis_tvalid, m_axis_tlast, overflow, error;
  logic [DW-1:0] m_axis_tdata;
  logic [8:0] level;
  always #5 tb_ACLK = ~tb_ACLK;
  axi_prefetch_stream_buf dut (
    .ACLK(tb_ACLK),
    .ARESETN(ARESETN),
    .enable(enable),
    .INIT_AXI_TXN(INIT_AXI_TXN),
    .TXN_DONE(TXN_DONE),
    .TXN_ERROR(TXN_ERROR),
    .in_valid(in_valid),
    .in_data(in_data),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .level(level),
    .overflow(overflow),
    .error(error)
  );
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] q[$];
  int acc_cnt, cyc, init_count, first_acc, last_acc;
  bit outst, halted, m_err, m_ovf, done_prev, m_init, last_tlast;
  bit p_valid, p_ready, p_last;
  logic [DW-1:0] p_data;
  int beats_left, done_wait, done_len;
  bit up_err, up_silent, burst_fast, init_s;
  logic [DW-1:0] data_ctr;
  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic drive_up();
    in_valid = 1'b0;
    if (init_s && !up_silent) begin
      beats_left = BL;
      TXN_DONE = 1'b0;
      TXN_ERROR = 1'b0;
    end else if (beats_left > 0) begin
      if (burst_fast || $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_data = data_ctr;
        data_ctr++;
        beats_left--;
        if (beats_left == 0) done_wait = $urandom_range(1, 3);
      end
    end else if (done_wait > 0) begin
      done_wait--;
      if (done_wait == 0) begin
        TXN_DONE = 1'b1;
        TXN_ERROR = up_err;
        done_len = $urandom_range(0, 3);
      end
    end else if (TXN_DONE && done_len > 0) begin
      done_len--;
      if (done_len == 0) TXN_DONE = 1'b0;
    end
  endtask
  task automatic cycle();
    bit acc, kick, rise;
    int sz;
    @(negedge tb_ACLK);
    cyc++;
    sz = q.size();
    check("level", level, sz);
    check("init", INIT_AXI_TXN, m_init);
    check("error", error, m_err);
    check("overflow", overflow, m_ovf);
    if (sz == 0) check("tvalid_empty", m_axis_tvalid, 0);
    if (p_valid && !p_ready) begin
      check("hold_valid", m_axis_tvalid, 1);
      check("hold_data", m_axis_tdata, p_data);
      check("hold_last", m_axis_tlast, p_last);
    end
    acc = m_axis_tvalid && m_axis_tready;
    if (acc) begin
      check("data", m_axis_tdata, sz > 0 ? q[0] : ~m_axis_tdata);
      check("tlast", m_axis_tlast, (acc_cnt % DEPTH) == DEPTH - 1);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      last_tlast = m_axis_tlast;
    end
    p_valid = m_axis_tvalid;
    p_ready = m_axis_tready;
    p_data = m_axis_tdata;
    p_last = m_axis_tlast;
    init_s = INIT_AXI_TXN;
    if (INIT_AXI_TXN) init_count++;
    if (acc) begin
      if (sz > 0) void'(q.pop_front());
      acc_cnt++;
    end
    if (in_valid) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else q.push_back(in_data);
    end
    rise = TXN_DONE && !done_prev;
    done_prev = TXN_DONE;
    kick = !outst && !halted && enable && (DEPTH - sz >= BL);
    if (outst && !m_init && rise) begin
      if (TXN_ERROR) begin
        halted = 1'b1;
        m_err = 1'b1;
      end else outst = 1'b0;
    end
    m_init = kick;
    if (kick) outst = 1'b1;
    @(posedge tb_ACLK);
    #1;
    drive_up();
  endtask
  task automatic do_reset(input int n);
    ARESETN = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(posedge tb_ACLK);
    #1;
    q.delete();
    acc_cnt = 0;
    first_acc = -1;
    last_acc = -1;
    {outst, halted, m_err, m_ovf, done_prev, m_init, p_valid, init_s} = '0;
    beats_left = 0;
    done_wait = 0;
    check("rst_level", level, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_init", INIT_AXI_TXN, 0);
    check("rst_overflow", overflow, 0);
    check("rst_error", error, 0);
    ARESETN = 1'b1;
  endtask
  initial begin
    int k0;
    {up_err, up_silent, burst_fast, init_count, cyc} = '0;
    data_ctr = 32'h100;
    do_reset(3);
    up_silent = 1'b1;
    enable = 1'b1;
    m_axis_tready = 1'b1;
    repeat (20) cycle();
    check("single_kick", init_count, 1);
    up_silent = 1'b0;
    beats_left = BL;
    for (int i = 0; i < 100 && (outst || q.size() != 0); i++) cycle();
    check("first_burst_done", acc_cnt, BL);
    repeat (5) cycle();
    check("rekick", init_count, 2);
    for (int i = 0; i < 3000; i++) begin
      cycle();
      enable = $urandom_range(7) != 0;
      m_axis_tready = $urandom_range(2) != 0;
    end
    enable = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 2000 && (outst || q.size() != 0 || beats_left != 0); i++) cycle();
    check("random_drain", outst || q.size() != 0, 0);
    do_reset(2);
    data_ctr = 32'h1000;
    burst_fast = 1'b1;
    enable = 1'b1;
    m_axis_tready = 1'b0;
    k0 = init_count;
    repeat (600) cycle();
    check("fill_level", level, DEPTH);
    check("fill_kicks", init_count - k0, DEPTH / BL);
    cycle();
    in_valid = 1'b1;
    in_data = 257;
    cycle();
    cycle();
    check("extra_overflow", overflow, 1);
    enable = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 400 && q.size() != 0; i++) cycle();
    check("fill_drained", acc_cnt, DEPTH);
    check("throughput", last_acc - first_acc, DEPTH - 1);
    check("frame_tlast", last_tlast, 1);
    do_reset(2);
    burst_fast = 1'b0;
    up_err = 1'b1;
    enable = 1'b1;
    k0 = init_count;
    for (int i = 0; i < 200; i++) begin
      cycle();
      m_axis_tready = $urandom_range(1);
    end
    check("halt_error", error, 1);
    check("halt_kicks", init_count - k0, 1);
    m_axis_tready = 1'b1;
    repeat (40) cycle();
    check("halt_drain", level, 0);
    up_err = 1'b0;
    do_reset(2);
    TXN_DONE = 1'b0;
    burst_fast = 1'b1;
    enable = 1'b1;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 100 && q.size() < 8; i++) cycle();
    check("mid_fill", level, 8);
    TXN_DONE = 1'b1;
    do_reset(1);
    k0 = init_count;
    repeat (10) cycle();
    check("post_rst_kick", init_count - k0, 1);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 100 && (outst || q.size() != 0); i++) cycle();
    check("post_rst_done", outst, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_prefetch_stream_buf.md
AXI_PREFETCH_STREAM_BUF -- requirements
Module: axi_prefetch_stream_buf

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of prefetched words and stream data.
REQ-002 Parameter DEPTH, 256, buffer depth in words (1 KiB at 32 bit), power of two.
REQ-003 Parameter BURST_LEN, 16, words delivered per prefetch transaction.
REQ-004 ACLK  input  1  single clock, all logic rising-edge.
REQ-005 ARESETN  input  1  reset, synchronous, active-low.
REQ-006 enable  input  1  level; 1 allows new prefetch kicks.
REQ-007 INIT_AXI_TXN  output  1  one-cycle pulse starting one upstream AXI prefetch burst.
REQ-008 TXN_DONE  input  1  upstream burst complete (level or pulse; rising edge used).
REQ-009 TXN_ERROR  input  1  upstream error flag, sampled with TXN_DONE rising edge.
REQ-010 in_valid  input  1  prefetched read-data beat valid.
REQ-011 in_data  input  DATA_WIDTH  prefetched read-data beat.
REQ-012 m_axis_tvalid  output  1  stream word valid.
REQ-013 m_axis_tdata  output  DATA_WIDTH  stream word.
REQ-014 m_axis_tlast  output  1  high on every DEPTH-th word emitted (1 KiB frame end).
REQ-015 m_axis_tready  input  1  downstream accepts word.
REQ-016 level  output  log2(DEPTH)+1  words stored, including output register.
REQ-017 overflow  output  1  sticky: beat arrived while buffer full.
REQ-018 error  output  1  sticky: TXN_ERROR seen at burst completion.

Function
REQ-019 Control FSM states IDLE, KICK, WAIT, HALT; reset to IDLE.
REQ-020 IDLE->KICK when enable=1 and (DEPTH - level - reserved) >= BURST_LEN; reserved = 0 in IDLE.
REQ-021 KICK lasts exactly one cycle with INIT_AXI_TXN=1, then ->WAIT; INIT_AXI_TXN=0 in all other states.
REQ-022 Entering KICK reserves BURST_LEN words, so free space never overcommits.
REQ-023 WAIT->IDLE on TXN_DONE rising edge with TXN_ERROR=0; reservation released; at most one burst outstanding.
REQ-024 WAIT->HALT on TXN_DONE rising edge with TXN_ERROR=1; error set; HALT exits only via reset.
REQ-025 enable deasserted in WAIT does not abort the burst; only further kicks are suppressed.
REQ-026 Each in_valid=1 cycle writes in_data at write pointer, pointer wraps modulo DEPTH; no backpressure upstream.
REQ-027 Beat arriving with level = DEPTH is dropped, overflow set, pointer and level unchanged.
REQ-028 Storage is one-cycle-read RAM plus output register; word written in cycle N first visible on m_axis no earlier than N+2.
REQ-029 m_axis_tvalid, once 1, holds with stable tdata/tlast until tvalid&tready.
REQ-030 Back-to-back transfers at one word per cycle sustained while buffer non-empty.
REQ-031 Simultaneous write and accepted read in same cycle leaves level unchanged.
REQ-032 Output word counter modulo DEPTH drives tlast; wraps to 0 after tlast accepted.
REQ-033 Reads proceed in HALT so buffered data drains; writes still accepted.

Reset
REQ-034 ARESETN=0 at rising edge: FSM IDLE, pointers/counters/level 0, INIT_AXI_TXN=0, m_axis_tvalid=0, tlast=0, overflow=0, error=0.
REQ-035 Reset mid-burst discards contents and reservation; TXN_DONE edge detector cleared so a stale high TXN_DONE is not counted.
REQ-036 RAM contents not reset.

Structure
REQ-037 Shared package axi_prefetch_pkg holds FSM state enum, DATA_WIDTH/DEPTH/BURST_LEN defaults, derived pointer width.
REQ-038 One sub-module: prefetch_sdp_ram (simple dual-port, one write port, registered read port).

Verification
REQ-039 Reset release, enable=1, no data -> single INIT_AXI_TXN pulse 1 cycle, no second pulse before TXN_DONE.
REQ-040 16 beats 0x100..0x10F, TXN_DONE, tready=1 -> stream 0x100..0x10F in order, level returns 0, new kick.
REQ-041 Fill 256 words with tready=0 -> kicks stop at level 240 reservation limit, level=256, tlast on 256th word after drain.
REQ-042 Force one extra beat at level=256 -> overflow=1, data 257 absent from stream.
REQ-043 TXN_DONE with TXN_ERROR=1 -> error=1, FSM HALT, no further kicks, buffered words still drain.
REQ-044 ARESETN low in WAIT with 8 words stored -> tvalid=0, level=0 next cycle, fresh kick after release.
